// File: rtl/mdio_responder_if.sv
// mdio_responder_if
//   Management-side signals of the MDIO responder, excluding the bidirectional
//   data line (io_mdio stays a plain inout on the module so tristate resolution
//   happens on a single net).
//   i_mdc     : management clock from the initiator (async to clk)
//   o_wr_dv   : one-clk pulse, register write committed
//   o_wr_addr : address of last committed write
//   o_wr_data : data of last committed write
//   o_rd_dv   : one-clk pulse, read frame completed
//   o_busy    : high from valid start-of-frame to end of frame
interface mdio_responder_if;
    logic        i_mdc;
    logic        o_wr_dv;
    logic [4:0]  o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_rd_dv;
    logic        o_busy;

    modport slave  (input  i_mdc, output o_wr_dv, o_wr_addr, o_wr_data, o_rd_dv, o_busy);
    modport master (output i_mdc, input  o_wr_dv, o_wr_addr, o_wr_data, o_rd_dv, o_busy);
endinterface

// File: rtl/mdio_responder.sv
// mdio_responder
//   Clause 22 MDIO management slave with a 32 x 16 register file. MDC and MDIO
//   are oversampled by clk; every synchronised MDC rising edge advances the
//   frame decoder by one bit. Registers 2/3 read as PHY_ID1/PHY_ID2 and ignore
//   writes.
//   Ports: clk, i_reset (async, active high), io_mdio (driven only during read
//   TA/data), bus (mdio_responder_if.slave: i_mdc in, write/read strobes and
//   busy out).
//   Build option: MDIO_PREAMBLE_SUPPRESS_EN -- accept a start-of-frame after a
//   single preamble 1 instead of 32.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd0,
    parameter logic [15:0] PHY_ID1  = 16'h0007,
    parameter logic [15:0] PHY_ID2  = 16'h0772
) (
    input  logic            clk,
    input  logic            i_reset,
    inout  wire             io_mdio,
    mdio_responder_if.slave bus
);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] PRE_NEED = 6'd1;
`else
    localparam logic [5:0] PRE_NEED = 6'd32;
`endif

    typedef enum logic [3:0] {
        S_PRE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    state_t      state, state_n;
    logic [1:0]  mdc_sync, mdio_sync;
    logic        mdc_q;
    logic        mdc_edge, bit_in;
    logic [5:0]  pre_cnt, pre_n;
    logic [4:0]  cnt, cnt_n;
    logic        op_rd, op_rd_n;
    logic [4:0]  addr, addr_n, addr_full;
    logic [15:0] shreg, sh_n, reg_rd;
    logic        oe, oe_n, dout, dout_n;
    logic        busy, busy_n, wr_dv, wr_dv_n, rd_dv, rd_dv_n, we;
    logic [4:0]  wr_addr, wa_n;
    logic [15:0] wr_data, wd_n;
    logic [15:0] regs [32];

    assign mdc_edge  = mdc_sync[1] & ~mdc_q;
    assign bit_in    = mdio_sync[1];
    assign addr_full = {addr[3:0], bit_in};

    // Reset drops the driver without waiting for a clock edge.
    assign io_mdio = (oe && !i_reset) ? dout : 1'bz;

    assign bus.o_wr_dv   = wr_dv;
    assign bus.o_wr_addr = wr_addr;
    assign bus.o_wr_data = wr_data;
    assign bus.o_rd_dv   = rd_dv;
    assign bus.o_busy    = busy;

    always_comb begin
        reg_rd = regs[addr_full];
        if (addr_full == 5'd2)      reg_rd = PHY_ID1;
        else if (addr_full == 5'd3) reg_rd = PHY_ID2;
    end

    always_comb begin
        state_n = state;  pre_n = pre_cnt;  cnt_n = cnt;   op_rd_n = op_rd;
        addr_n  = addr;   sh_n  = shreg;    oe_n  = oe;    dout_n  = dout;
        busy_n  = busy;   wr_dv_n = 1'b0;   rd_dv_n = 1'b0;
        wa_n    = wr_addr; wd_n = wr_data;  we = 1'b0;
        if (mdc_edge) begin
            case (state)
                S_PRE: begin
                    if (bit_in) begin
                        if (pre_cnt != 6'd32) pre_n = pre_cnt + 6'd1;
                    end else begin
                        if (pre_cnt >= PRE_NEED) state_n = S_ST2;
                        pre_n = '0;
                    end
                end
                S_ST2: begin
                    if (bit_in) begin
                        busy_n = 1'b1; state_n = S_OP; cnt_n = '0;
                    end else begin
                        state_n = S_PRE;
                    end
                end
                S_OP: begin
                    if (cnt == 5'd0) begin
                        op_rd_n = bit_in;   // first OP bit 1 => read if valid
                        cnt_n   = 5'd1;
                    end else if (op_rd ^ bit_in) begin
                        state_n = S_PHYAD; cnt_n = '0;
                    end else begin
                        state_n = S_PRE; busy_n = 1'b0;
                    end
                end
                S_PHYAD: begin
                    addr_n = addr_full;
                    cnt_n  = cnt + 5'd1;
                    if (cnt == 5'd4) begin
                        cnt_n   = '0;
                        state_n = (addr_full == PHY_ADDR) ? S_REGAD : S_IGNORE;
                    end
                end
                S_REGAD: begin
                    addr_n = addr_full;
                    cnt_n  = cnt + 5'd1;
                    if (cnt == 5'd4) begin
                        cnt_n   = '0;
                        state_n = S_TA;
                        if (op_rd) sh_n = reg_rd;
                    end
                end
                S_TA: begin
                    if (cnt == 5'd0) begin
                        // Drive 0 now so the initiator samples it as TA bit 2.
                        if (op_rd) begin
                            oe_n = 1'b1; dout_n = 1'b0;
                        end
                        cnt_n = 5'd1;
                    end else begin
                        cnt_n = '0;
                        if (op_rd) begin
                            dout_n  = shreg[15];
                            sh_n    = {shreg[14:0], 1'b0};
                            state_n = S_RDATA;
                        end else begin
                            state_n = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (cnt == 5'd15) begin
                        oe_n = 1'b0; rd_dv_n = 1'b1; busy_n = 1'b0;
                        state_n = S_PRE; cnt_n = '0;
                    end else begin
                        dout_n = shreg[15];
                        sh_n   = {shreg[14:0], 1'b0};
                        cnt_n  = cnt + 5'd1;
                    end
                end
                S_WDATA: begin
                    sh_n  = {shreg[14:0], bit_in};
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        if (addr != 5'd2 && addr != 5'd3) begin
                            we = 1'b1; wr_dv_n = 1'b1;
                            wa_n = addr; wd_n = {shreg[14:0], bit_in};
                        end
                        busy_n = 1'b0; state_n = S_PRE; cnt_n = '0;
                    end
                end
                S_IGNORE: begin
                    // Swallow REGAD + TA + data of a frame for another PHY.
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'd22) begin
                        busy_n = 1'b0; state_n = S_PRE; cnt_n = '0;
                    end
                end
                default: begin
                    state_n = S_PRE; busy_n = 1'b0; oe_n = 1'b0; pre_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            mdc_sync <= '0;  mdio_sync <= '0; mdc_q <= 1'b0;
            state    <= S_PRE; pre_cnt <= '0; cnt <= '0; op_rd <= 1'b0;
            addr     <= '0;  shreg <= '0;     oe <= 1'b0; dout <= 1'b0;
            busy     <= 1'b0; wr_dv <= 1'b0;  rd_dv <= 1'b0;
            wr_addr  <= '0;  wr_data <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            mdc_sync  <= {mdc_sync[0], bus.i_mdc};
            mdio_sync <= {mdio_sync[0], io_mdio};
            mdc_q     <= mdc_sync[1];
            state   <= state_n;  pre_cnt <= pre_n;  cnt  <= cnt_n;  op_rd <= op_rd_n;
            addr    <= addr_n;   shreg   <= sh_n;   oe   <= oe_n;   dout  <= dout_n;
            busy    <= busy_n;   wr_dv   <= wr_dv_n; rd_dv <= rd_dv_n;
            wr_addr <= wa_n;     wr_data <= wd_n;
            if (we) regs[wa_n] <= wd_n;
        end
    end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder
//   Acts as the MDIO initiator: bit-bangs Clause 22 frames on i_mdc/io_mdio
//   (MDC period 8 clk), samples io_mdio just before each MDC rise, and checks
//   read data, strobes, busy and bus release against expected values.
module tb_mdio_responder;
    localparam int HALF = 4;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic [16:0] exp_cap;   // {TA bit 2, data[15:0]} seen by the initiator
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic tb_oe = 1'b0;
    logic tb_do = 1'b1;
    wire  io_mdio;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [20:0] wr_q [$];
    logic [16:0] rd_q [$];

    assign io_mdio = tb_oe ? tb_do : 1'bz;
    pullup pu (io_mdio);

    mdio_responder_if bus ();

    mdio_responder dut (
        .clk     (clk),
        .i_reset (i_reset),
        .io_mdio (io_mdio),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write scoreboard: every committed write must match the oldest expected one.
    always @(negedge clk) begin
        logic [20:0] e;
        if (bus.o_wr_dv) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: addr %h data %h, no write expected",
                         bus.o_wr_addr, bus.o_wr_data);
            end else begin
                e = wr_q.pop_front();
                chk("wr_addr", {27'd0, bus.o_wr_addr}, {27'd0, e[20:16]});
                chk("wr_data", {16'd0, bus.o_wr_data}, {16'd0, e[15:0]});
            end
        end
        if (bus.o_rd_dv) rd_cnt++;
    end

    task automatic bit_cycle(input logic en, input logic v, output logic s);
        bus.i_mdc = 1'b0; tb_oe = en; tb_do = v;
        repeat (HALF) @(negedge clk);
        s = io_mdio;
        bus.i_mdc = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // nbits counts bits after the preamble (32 = complete frame).
    task automatic frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] wd, input int nbits,
                         output logic [16:0] cap);
        logic [31:0] seq;
        logic        s;
        logic        rd;
        seq = {2'b01, op, phy, ra, 2'b10, wd};
        rd  = (op == 2'b10);
        cap = '0;
        for (int i = 0; i < pre_len; i++) bit_cycle(1'b1, 1'b1, s);
        for (int i = 0; i < nbits; i++) begin
            bit_cycle(!(rd && i >= 14), seq[31-i], s);
            if (i >= 15) cap = {cap[15:0], s};
        end
    endtask

    task automatic idle(input int n);
        tb_oe = 1'b0; bus.i_mdc = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic read_chk(input string name, input int pre_len, input logic [4:0] ra,
                            input logic [16:0] exp_cap, input int exp_rd);
        logic [16:0] cap;
        int r0;
        r0 = rd_cnt;
        rd_q.push_back(exp_cap);
        frame(pre_len, 2'b10, 5'd0, ra, 16'h0, 32, cap);
        idle(6);
        chk({name, "_data"}, {15'd0, cap}, {15'd0, rd_q.pop_front()});
        chk({name, "_rd_dv"}, rd_cnt - r0, exp_rd);
        chk({name, "_release"}, {31'd0, io_mdio}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1);
    end

    initial begin
        vec_t        vt [15];
        logic [16:0] cap;
        logic        s, seen0;
        int          w0, r0;

        vt[0]  = '{2'b01, 5'd0, 5'd5,  16'hBEEF, 17'h00000, 1, 0};
        vt[1]  = '{2'b10, 5'd0, 5'd5,  16'h0000, 17'h0BEEF, 0, 1};
        vt[2]  = '{2'b10, 5'd0, 5'd2,  16'h0000, 17'h00007, 0, 1};
        vt[3]  = '{2'b10, 5'd0, 5'd3,  16'h0000, 17'h00772, 0, 1};
        vt[4]  = '{2'b01, 5'd0, 5'd3,  16'h1234, 17'h00000, 0, 0};
        vt[5]  = '{2'b10, 5'd0, 5'd3,  16'h0000, 17'h00772, 0, 1};
        vt[6]  = '{2'b10, 5'd1, 5'd5,  16'h0000, 17'h1FFFF, 0, 0};
        vt[7]  = '{2'b10, 5'd0, 5'd5,  16'h0000, 17'h0BEEF, 0, 1};
        vt[8]  = '{2'b01, 5'd0, 5'd31, 16'hA5C3, 17'h00000, 1, 0};
        vt[9]  = '{2'b10, 5'd0, 5'd31, 16'h0000, 17'h0A5C3, 0, 1};
        vt[10] = '{2'b01, 5'd0, 5'd2,  16'hFFFF, 17'h00000, 0, 0};
        vt[11] = '{2'b10, 5'd0, 5'd2,  16'h0000, 17'h00007, 0, 1};
        vt[12] = '{2'b10, 5'd0, 5'd7,  16'h0000, 17'h00000, 0, 1};
        vt[13] = '{2'b01, 5'd1, 5'd6,  16'h5555, 17'h00000, 0, 0};
        vt[14] = '{2'b10, 5'd0, 5'd6,  16'h0000, 17'h00000, 0, 1};

        bus.i_mdc = 1'b0;
        repeat (5) @(negedge clk);
        i_reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mdio_z",  {31'd0, io_mdio},        32'd1);
        chk("rst_busy",    {31'd0, bus.o_busy},     32'd0);
        chk("rst_wr_dv",   {31'd0, bus.o_wr_dv},    32'd0);
        chk("rst_rd_dv",   {31'd0, bus.o_rd_dv},    32'd0);
        chk("rst_wr_addr", {27'd0, bus.o_wr_addr},  32'd0);
        chk("rst_wr_data", {16'd0, bus.o_wr_data},  32'd0);

        // Back-to-back frames at the minimum MDC period.
        for (int k = 0; k < 15; k++) begin
            w0 = wr_cnt; r0 = rd_cnt;
            if (vt[k].exp_wr != 0) wr_q.push_back({vt[k].ra, vt[k].wd});
            if (vt[k].op == 2'b10) rd_q.push_back(vt[k].exp_cap);
            frame(32, vt[k].op, vt[k].phy, vt[k].ra, vt[k].wd, 32, cap);
            idle(6);
            if (vt[k].op == 2'b10)
                chk($sformatf("v%0d_cap", k), {15'd0, cap}, {15'd0, rd_q.pop_front()});
            chk($sformatf("v%0d_wr_cnt", k), wr_cnt - w0, vt[k].exp_wr);
            chk($sformatf("v%0d_rd_cnt", k), rd_cnt - r0, vt[k].exp_rd);
            chk($sformatf("v%0d_busy", k), {31'd0, bus.o_busy}, 32'd0);
        end

        // 16-bit preamble
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        read_chk("short_pre", 16, 5'd5, 17'h0BEEF, 1);
`else
        read_chk("short_pre", 16, 5'd5, 17'h1FFFF, 0);
`endif

        // Invalid OP 11 after a valid ST.
        w0 = wr_cnt; r0 = rd_cnt;
        frame(32, 2'b11, 5'd0, 5'd5, 16'h0, 3, cap);
        chk("badop_busy_set", {31'd0, bus.o_busy}, 32'd1);
        bit_cycle(1'b1, 1'b1, s);
        chk("badop_busy_clr", {31'd0, bus.o_busy}, 32'd0);
        seen0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_cycle(1'b0, 1'b1, s);
            if (s !== 1'b1) seen0 = 1'b1;
        end
        idle(6);
        chk("badop_no_drive", {31'd0, seen0}, 32'd0);
        chk("badop_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        read_chk("after_badop", 32, 5'd5, 17'h0BEEF, 1);

        // Reset during data bit 8 of a read of reg 2 (data[7] = 0 is on the line).
        frame(32, 2'b10, 5'd0, 5'd2, 16'h0, 24, cap);
        chk("midrd_driving", {31'd0, io_mdio},    32'd0);
        chk("midrd_busy",    {31'd0, bus.o_busy}, 32'd1);
        i_reset = 1'b1;
        #1;
        chk("midrd_rst_z",    {31'd0, io_mdio},    32'd1);
        chk("midrd_rst_busy", {31'd0, bus.o_busy}, 32'd0);
        bus.i_mdc = 1'b0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        idle(4);
        chk("midrd_wr_addr", {27'd0, bus.o_wr_addr}, 32'd0);
        read_chk("post_rst_reg5", 32, 5'd5, 17'h00000, 1);
        read_chk("post_rst_reg3", 32, 5'd3, 17'h00772, 1);
        w0 = wr_cnt;
        wr_q.push_back({5'd9, 16'h0F0F});
        frame(32, 2'b01, 5'd0, 5'd9, 16'h0F0F, 32, cap);
        idle(6);
        chk("post_rst_wr_cnt", wr_cnt - w0, 1);
        read_chk("post_rst_reg9", 32, 5'd9, 17'h00F0F, 1);
        chk("wr_q_empty", wr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
